apb_initiator: RTL and testbench
================================

# apb_initiator

Bridges a simple memory-request interface (mreq/maddr/mwe/mwdata/mstrb → mack/mrdata/mresp) to an APB4 requester port, one transfer at a time. It is the initiator counterpart of the APB memory interface inside the UART peripheral. Typical uses are a test/bring-up controller or a small CPU-side fabric driving the UART register block. An optional PREADY timeout keeps a hung responder from stalling the requester forever.

## Interface
- ADDR_WIDTH, 5, width of maddr_i/paddr_o
- DATA_WIDTH, 32, width of data buses; multiple of 8
- TIMEOUT, 16, max ACCESS cycles waiting for pready_i; 0 disables timeout
- clk_i  input  1  clock; all logic on rising edge
- arst_ni  input  1  one clock; reset is synchronous and active-low
- mreq_i  input  1  request valid; held with fields stable until mack_o
- maddr_i  input  ADDR_WIDTH  request address
- mwe_i  input  1  1 = write, 0 = read
- mwdata_i  input  DATA_WIDTH  write data
- mstrb_i  input  DATA_WIDTH/8  write byte strobes
- mack_o  output  1  one-cycle completion pulse
- mrdata_o  output  DATA_WIDTH  read data, valid with mack_o
- mresp_o  output  1  error flag (pslverr or timeout), valid with mack_o
- psel_o, penable_o, pwrite_o  output  1 each  APB control
- paddr_o  output  ADDR_WIDTH  APB address
- pwdata_o  output  DATA_WIDTH  APB write data
- pstrb_o  output  DATA_WIDTH/8  APB strobes
- pready_i, pslverr_i  input  1 each  APB responder status
- prdata_i  input  DATA_WIDTH  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if mreq_i=1, register maddr_i, mwe_i, mwdata_i, mstrb_i; go to SETUP. Otherwise stay.
- SETUP: psel_o=1, penable_o=0; go to ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1.
  - If pready_i=1, capture prdata_i (reads only; writes capture 0) and pslverr_i; go to RESP.
  - If pready_i=0 and TIMEOUT≠0 and wait counter = TIMEOUT-1, go to RESP with mresp_o=1 and mrdata_o=0.
  - Otherwise increment wait counter.
- RESP: mack_o=1 for exactly this cycle, with mrdata_o/mresp_o valid; go to IDLE. mreq_i is ignored in RESP.
- paddr_o, pwrite_o, pwdata_o, pstrb_o are registered and stable from SETUP through the last ACCESS cycle.
- Reads drive pwdata_o=0 and pstrb_o=0, per APB4.
- Wait counter is $clog2(TIMEOUT+1) bits. It clears on entry to SETUP and saturates, never wraps.
- Protocol-level pslverr_i is meaningful only when pready_i=1; it is ignored otherwise.

## Timing
- Reset (arst_ni=0 at a rising edge): state IDLE; all outputs 0, including mrdata_o and mresp_o; counter 0.
- Reset mid-transfer aborts immediately, dropping psel_o and penable_o the next cycle, and issues no mack_o.
- Request seen in IDLE at cycle 0: SETUP at cycle 1, ACCESS at cycle 2.
- Zero-wait responder: pready_i=1 at cycle 2 gives mack_o at cycle 3. Minimum latency is 3 cycles.
- Minimum spacing between transfers is 4 cycles, since a new request is accepted in IDLE at cycle 4.
- Each pready_i=0 cycle adds one cycle of latency.
- Timeout: with TIMEOUT=N and pready_i held low, there are exactly N ACCESS cycles and mack_o comes at cycle 2+N.
- pready_i=1 on the final timeout cycle counts as a normal completion; pready_i takes priority over timeout.
- mrdata_o and mresp_o hold their values after mack_o until the next RESP.

## Structure
- The shared package apb_uart_pkg holds typedef enum logic [1:0] apb_init_state_e {IDLE, SETUP, ACCESS, RESP}.
- Single flat module; no sub-module is warranted.
- Counter width is computed locally from TIMEOUT.

## Test plan
- Write, zero-wait responder: addr 0x04, data 0xDEADBEEF, strb 0xF → psel at cycle 1, penable at cycle 2 with pwdata=0xDEADBEEF and pstrb=0xF, mack at cycle 3, mresp=0.
- Read with 3 wait states: prdata=0x12345678 → ACCESS lasts 4 cycles, mack at cycle 6, mrdata=0x12345678, pstrb=0 throughout.
- pslverr_i=1 with pready_i on a read → mack with mresp=1; mrdata equals the prdata sampled that cycle.
- TIMEOUT=4, responder never ready → 4 ACCESS cycles, psel drops, mack at cycle 6 with mresp=1 and mrdata=0. Then pready_i=1 exactly on the 4th cycle → normal completion with mresp=0.
- Back-to-back: mreq held high across two transfers → second SETUP at cycle 5 (IDLE at 4). APB signals stay stable during wait states; mack never lasts more than 1 cycle.
- Reset asserted during ACCESS → next cycle psel=penable=0 and all outputs 0, no mack. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB/UART codebase slice.
package apb_uart_pkg;

    // Phases of the APB initiator transfer sequence.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_init_state_e;

    // Width of a byte in the strobe mapping.
    localparam int APB_BYTE_W = 8;

endpackage : apb_uart_pkg

// File: rtl/apb_initiator.sv
// Memory-request to APB4 requester bridge, one transfer at a time.
//
// Handshake: the requester raises mreq_i with maddr_i/mwe_i/mwdata_i/mstrb_i
// stable and keeps them until it sees the one-cycle mack_o pulse; the request
// is only sampled in IDLE, so a request still high during RESP is ignored and
// is taken as a new transfer on the following IDLE cycle. mrdata_o/mresp_o are
// valid with mack_o and hold until the next completion.
module apb_initiator
    import apb_uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    mreq_i,
    input  logic [ADDR_WIDTH-1:0]   maddr_i,
    input  logic                    mwe_i,
    input  logic [DATA_WIDTH-1:0]   mwdata_i,
    input  logic [DATA_WIDTH/8-1:0] mstrb_i,
    output logic                    mack_o,
    output logic [DATA_WIDTH-1:0]   mrdata_o,
    output logic                    mresp_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i
);

    localparam int STRB_W = DATA_WIDTH / APB_BYTE_W;
    // A zero TIMEOUT still needs a legal one-bit counter; it is simply never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    apb_init_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    resp_q, resp_d;

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state and capture logic for the transfer sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;

        unique case (state_q)
            IDLE: begin
                if (mreq_i) begin
                    addr_d  = maddr_i;
                    write_d = mwe_i;
                    // Reads present zero data and zero strobes on the APB side.
                    wdata_d = mwe_i ? mwdata_i : '0;
                    strb_d  = mwe_i ? mstrb_i : '0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready_i wins over an expiring timeout on the same cycle.
                if (pready_i) begin
                    rdata_d = write_q ? '0 : prdata_i;
                    resp_d  = pslverr_i;
                    state_d = RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    resp_d  = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // APB control and completion strobes decode directly from the state register.
    always_comb begin
        psel_o    = (state_q == SETUP) || (state_q == ACCESS);
        penable_o = (state_q == ACCESS);
        mack_o    = (state_q == RESP);
    end

    assign pwrite_o = write_q;
    assign paddr_o  = addr_q;
    assign pwdata_o = wdata_q;
    assign pstrb_o  = strb_q;
    assign mrdata_o = rdata_q;
    assign mresp_o  = resp_q;

endmodule : apb_initiator

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: cycle-accurate per-transfer tasks plus a
// completion scoreboard fed when each request is driven.
module tb_apb_initiator;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_ni;
  logic          mreq_i;
  logic [AW-1:0] maddr_i;
  logic          mwe_i;
  logic [DW-1:0] mwdata_i;
  logic [SW-1:0] mstrb_i;
  logic          mack_o;
  logic [DW-1:0] mrdata_o;
  logic          mresp_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i;
  logic          pslverr_i;
  logic [DW-1:0] prdata_i;

  apb_initiator #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i    (clk),
    .arst_ni  (arst_ni),
    .mreq_i   (mreq_i),
    .maddr_i  (maddr_i),
    .mwe_i    (mwe_i),
    .mwdata_i (mwdata_i),
    .mstrb_i  (mstrb_i),
    .mack_o   (mack_o),
    .mrdata_o (mrdata_o),
    .mresp_o  (mresp_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .pwrite_o (pwrite_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .pstrb_o  (pstrb_o),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i),
    .prdata_i (prdata_i)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  // Each entry is {mresp, mrdata} expected at the matching mack_o pulse.
  logic [DW:0] exp_q[$];
  logic [DW-1:0] last_rdata;
  logic          last_resp;

  always @(negedge clk) begin
    if (mack_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_mack: mack with empty queue, mresp=%0b mrdata=%h", mresp_o, mrdata_o);
      end else begin
        logic [DW:0] exp;
        exp = exp_q.pop_front();
        if ({mresp_o, mrdata_o} !== exp) begin
          errors++;
          $display("FAIL sb_completion: got mresp=%0b mrdata=%h, want mresp=%0b mrdata=%h",
                   mresp_o, mrdata_o, exp[DW], exp[DW-1:0]);
        end
      end
    end
  end

  // Global watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want run to finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer starting in an IDLE cycle (cycle 0). waits = number of
  // pready_i=0 cycles before pready_i=1; waits >= TO means the timeout fires.
  // chain keeps mreq_i high through RESP so the next call starts at cycle 4.
  task automatic do_xfer(input string name, input logic [AW-1:0] addr, input logic we,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                         input int waits, input logic [DW-1:0] rdata,
                         input logic slverr, input logic chain);
    int            acc;
    logic          tmo;
    logic [DW-1:0] exp_pw;
    logic [SW-1:0] exp_ps;
    logic [DW-1:0] exp_rd;
    logic          exp_resp;
    tmo      = (waits >= TO);
    acc      = tmo ? TO : waits + 1;
    exp_pw   = we ? wdata : '0;
    exp_ps   = we ? strb : '0;
    exp_rd   = (tmo || we) ? '0 : rdata;
    exp_resp = tmo ? 1'b1 : slverr;

    // cycle 0: IDLE, previous completion values still held
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || mack_o !== 1'b0 ||
        mrdata_o !== last_rdata || mresp_o !== last_resp) begin
      errors++;
      $display("FAIL %s_idle: psel=%0b pen=%0b mack=%0b mrdata=%h mresp=%0b, want 0 0 0 %h %0b",
               name, psel_o, penable_o, mack_o, mrdata_o, mresp_o, last_rdata, last_resp);
    end
    mreq_i   = 1'b1;
    maddr_i  = addr;
    mwe_i    = we;
    mwdata_i = wdata;
    mstrb_i  = strb;
    exp_q.push_back({exp_resp, exp_rd});
    tick;

    // cycle 1: SETUP
    checks++;
    if ({psel_o, penable_o, mack_o} !== 3'b100 || paddr_o !== addr || pwrite_o !== we ||
        pwdata_o !== exp_pw || pstrb_o !== exp_ps) begin
      errors++;
      $display("FAIL %s_setup: sel/en/ack=%b addr=%h wr=%0b wdata=%h strb=%h, want 100 %h %0b %h %h",
               name, {psel_o, penable_o, mack_o}, paddr_o, pwrite_o, pwdata_o, pstrb_o,
               addr, we, exp_pw, exp_ps);
    end
    tick;

    // cycles 2 .. 1+acc: ACCESS, APB fields must stay stable
    for (int c = 0; c < acc; c++) begin
      checks++;
      if ({psel_o, penable_o, mack_o} !== 3'b110 || paddr_o !== addr || pwrite_o !== we ||
          pwdata_o !== exp_pw || pstrb_o !== exp_ps) begin
        errors++;
        $display("FAIL %s_access%0d: sel/en/ack=%b addr=%h wr=%0b wdata=%h strb=%h, want 110 %h %0b %h %h",
                 name, c, {psel_o, penable_o, mack_o}, paddr_o, pwrite_o, pwdata_o, pstrb_o,
                 addr, we, exp_pw, exp_ps);
      end
      if (c == waits) begin
        pready_i  = 1'b1;
        prdata_i  = rdata;
        pslverr_i = slverr;
      end else begin
        // pslverr_i and prdata_i are noise while pready_i is low
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom_range(0, 1));
      end
      tick;
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = $urandom;

    // cycle 2+acc: RESP
    checks++;
    if ({psel_o, penable_o, mack_o} !== 3'b001) begin
      errors++;
      $display("FAIL %s_resp_cycle%0d: sel/en/ack=%b, want 001", name, 2 + acc,
               {psel_o, penable_o, mack_o});
    end
    if (!chain) mreq_i = 1'b0;
    last_rdata = exp_rd;
    last_resp  = exp_resp;
    tick;

    // cycle 3+acc: back in IDLE, single-cycle mack, results held
    checks++;
    if (mack_o !== 1'b0 || psel_o !== 1'b0 || mrdata_o !== exp_rd || mresp_o !== exp_resp) begin
      errors++;
      $display("FAIL %s_after: mack=%0b psel=%0b mrdata=%h mresp=%0b, want 0 0 %h %0b",
               name, mack_o, psel_o, mrdata_o, mresp_o, exp_rd, exp_resp);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || mack_o !== 1'b0 || pwrite_o !== 1'b0 ||
        paddr_o !== '0 || pwdata_o !== '0 || pstrb_o !== '0 || mrdata_o !== '0 ||
        mresp_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: sel=%0b en=%0b ack=%0b wr=%0b addr=%h wd=%h st=%h rd=%h resp=%0b, want all 0",
               name, psel_o, penable_o, mack_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
               mrdata_o, mresp_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    arst_ni   = 1'b0;
    mreq_i    = 1'b0;
    maddr_i   = '0;
    mwe_i     = 1'b0;
    mwdata_i  = '0;
    mstrb_i   = '0;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = '0;
    repeat (3) tick;
    check_all_zero("reset_state");
    arst_ni = 1'b1;
    tick;
    check_all_zero("after_reset_release");
    last_rdata = '0;
    last_resp  = 1'b0;
  endtask

  task automatic test_write_zero_wait;
    do_xfer("wr0", 5'h04, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'hFFFF_0000, 1'b0, 1'b0);
  endtask

  task automatic test_read_waits;
    do_xfer("rd3", 5'h08, 1'b0, 32'hAAAA5555, 4'hF, 3, 32'h12345678, 1'b0, 1'b0);
  endtask

  task automatic test_slverr;
    do_xfer("rderr", 5'h0C, 1'b0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1'b1, 1'b0);
    do_xfer("wrerr", 5'h10, 1'b1, 32'h0BAD0BAD, 4'h3, 0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    do_xfer("tmo_rd", 5'h14, 1'b0, 32'h0, 4'h0, 100, 32'h55555555, 1'b0, 1'b0);
    do_xfer("tmo_edge", 5'h18, 1'b0, 32'h0, 4'h0, TO - 1, 32'h87654321, 1'b0, 1'b0);
    do_xfer("tmo_wr", 5'h1C, 1'b1, 32'h11112222, 4'h5, 100, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_xfer("b2b_a", 5'h01, 1'b1, 32'h01020304, 4'hA, 0, 32'h0, 1'b0, 1'b1);
    do_xfer("b2b_b", 5'h02, 1'b0, 32'h0, 4'h0, 2, 32'hA5A5F00F, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_xfer("b2b_rand", AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
              SW'($urandom_range(0, 15)), $urandom_range(0, 5), $urandom,
              1'($urandom_range(0, 1)), (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    // leave non-zero completion data behind first so the reset has work to do
    do_xfer("pre_rst", 5'h03, 1'b0, 32'h0, 4'h0, 0, 32'hFEEDFACE, 1'b1, 1'b0);
    mreq_i   = 1'b1;
    maddr_i  = 5'h1E;
    mwe_i    = 1'b1;
    mwdata_i = 32'h99887766;
    mstrb_i  = 4'hC;
    tick;
    tick;
    checks++;
    if ({psel_o, penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_access: sel/en=%b, want 11", {psel_o, penable_o});
    end
    pready_i = 1'b0;
    arst_ni  = 1'b0;
    mreq_i   = 1'b0;
    tick;
    check_all_zero("rst_mid_abort");
    arst_ni = 1'b1;
    tick;
    check_all_zero("rst_mid_release");
    last_rdata = '0;
    last_resp  = 1'b0;
    do_xfer("post_rst", 5'h05, 1'b0, 32'h0, 4'h0, 1, 32'h0F0F0F0F, 1'b0, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d completions outstanding, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_apb_initiator
